// File: rtl/axil_led_pwm.sv
// AXI4-Lite slave driving N_CHANNELS LED outputs in PWM or blink mode.
// One shared prescaler and period counter keep every channel phase-aligned.
module axil_led_pwm #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int N_CHANNELS     = 6,
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                    axi_clock,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [N_CHANNELS-1:0]   pwm_out
);

  localparam int unsigned IDX_W   = ADDR_WIDTH - 2;
  localparam int unsigned N_WORDS = 2 ** IDX_W;
  localparam int unsigned N_BYTES = DATA_WIDTH / 8;
  localparam int unsigned N_REGS  = 4 + N_CHANNELS;

  logic                      gen;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PWM_WIDTH-1:0]      duty [N_CHANNELS];
  logic [N_CHANNELS-1:0]     mode;
  logic [N_CHANNELS-1:0]     en;

  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [PWM_WIDTH-1:0]      cnt;
  logic [N_CHANNELS-1:0]     toggle;
  logic                      tick;
  logic                      wrap;
  logic [N_CHANNELS-1:0]     pwm_nxt;

  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          rd_idx;
  logic                      wr_acc;
  logic                      rd_acc;
  logic [DATA_WIDTH-1:0]     wr_merged;
  logic [DATA_WIDTH-1:0]     reg_img [N_WORDS];
  logic                      reg_ok  [N_WORDS];
  logic                      unused_inputs;

  assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign wr_idx = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:2];

  assign wr_acc = !rst && s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
  assign rd_acc = !rst && s_axil_arvalid && !s_axil_rvalid;

  assign s_axil_awready = wr_acc;
  assign s_axil_wready  = wr_acc;
  assign s_axil_arready = rd_acc;

  // Read image of every decoded word; undecoded words stay zero and flag SLVERR.
  always_comb begin
    for (int unsigned w = 0; w < N_WORDS; w++) begin
      reg_img[IDX_W'(w)] = '0;
      reg_ok[IDX_W'(w)]  = (w < N_REGS);
    end
    reg_img[IDX_W'(0)][0]                    = gen;
    reg_img[IDX_W'(1)][PRESCALE_WIDTH-1:0]   = prescale;
    reg_img[IDX_W'(2)][15:0]                 = {8'(PWM_WIDTH), 8'(N_CHANNELS)};
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      reg_img[IDX_W'(4 + i)][PWM_WIDTH-1:0] = duty[i];
      reg_img[IDX_W'(4 + i)][16]            = mode[i];
      reg_img[IDX_W'(4 + i)][31]            = en[i];
    end
  end

  always_comb begin
    wr_merged = reg_img[wr_idx];
    for (int unsigned b = 0; b < N_BYTES; b++) begin
      if (s_axil_wstrb[b]) begin
        wr_merged[8*b +: 8] = s_axil_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
      gen           <= 1'b0;
      prescale      <= '0;
      mode          <= '0;
      en            <= '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        duty[i] <= '0;
      end
    end else begin
      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (wr_acc) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= reg_ok[wr_idx] ? 2'b00 : 2'b10;
        if (wr_idx == IDX_W'(0)) begin
          gen <= wr_merged[0];
        end
        if (wr_idx == IDX_W'(1)) begin
          prescale <= wr_merged[PRESCALE_WIDTH-1:0];
        end
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
          if (wr_idx == IDX_W'(4 + i)) begin
            duty[i] <= wr_merged[PWM_WIDTH-1:0];
            mode[i] <= wr_merged[16];
            en[i]   <= wr_merged[31];
          end
        end
      end
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= 2'b00;
      s_axil_rdata  <= '0;
    end else begin
      if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
      if (rd_acc) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= reg_img[rd_idx];
        s_axil_rresp  <= reg_ok[rd_idx] ? 2'b00 : 2'b10;
      end
    end
  end

  assign tick = gen && (pcnt == prescale);
  assign wrap = tick && (cnt == '1);

  // A PRESCALE write restarts the prescaler even if that edge is also a tick.
  always_ff @(posedge axi_clock) begin
    if (rst || !gen) begin
      pcnt   <= '0;
      cnt    <= '0;
      toggle <= '0;
    end else begin
      if ((wr_acc && wr_idx == IDX_W'(1)) || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_WIDTH'(1);
      end
      if (tick) begin
        cnt <= cnt + PWM_WIDTH'(1);
      end
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
        if (!en[i]) begin
          toggle[i] <= 1'b0;
        end else if (wrap) begin
          toggle[i] <= !toggle[i];
        end
      end
    end
  end

  always_comb begin
    pwm_nxt = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      pwm_nxt[i] = gen && en[i] && (mode[i] ? toggle[i] : (cnt < duty[i]));
    end
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_axil_led_pwm.sv
// Randomized scoreboard bench for axil_led_pwm: a tick-counting reference model
// predicts handshakes, responses and LED outputs; monitors compare on the falling edge.
module tb_axil_led_pwm;

  localparam int AW  = 6;
  localparam int NC  = 6;
  localparam int PW  = 8;
  localparam int PSW = 16;
  localparam longint unsigned PERIOD = 2 ** PW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic [NC-1:0] pwm_out;

  always #5 clk = ~clk;

  axil_led_pwm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .N_CHANNELS(NC),
    .PWM_WIDTH(PW), .PRESCALE_WIDTH(PSW)
  ) dut (
    .axi_clock(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready), .pwm_out(pwm_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int b_hold   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: register contents, tick count since GEN rose, blink parity.
  bit              m_gen;
  int unsigned     m_presc;
  int unsigned     m_duty [NC];
  bit              m_mode [NC];
  bit              m_en   [NC];
  bit              m_tog  [NC];
  longint unsigned m_phase, m_ticks;
  bit              m_bv, m_rv;
  logic [NC-1:0]   exp_pwm;
  logic [1:0]      bq [$];
  logic [33:0]     rq [$];

  function automatic logic [31:0] m_img(input int idx);
    logic [31:0] v;
    v = '0;
    if (idx == 0) v[0] = m_gen;
    else if (idx == 1) v = m_presc;
    else if (idx == 2) v = (PW << 8) | NC;
    else if (idx >= 4 && idx < 4 + NC) begin
      v = m_duty[idx-4];
      v[16] = m_mode[idx-4];
      v[31] = m_en[idx-4];
    end
    return v;
  endfunction

  function automatic bit m_ok(input int idx);
    return idx < 4 + NC;
  endfunction

  always @(posedge clk) begin
    bit wacc, racc, tick, wrap;
    int widx, ridx;
    logic [31:0] mrg;
    if (rst) begin
      m_gen = 0; m_presc = 0; m_phase = 0; m_ticks = 0; m_bv = 0; m_rv = 0;
      for (int i = 0; i < NC; i++) begin
        m_duty[i] = 0; m_mode[i] = 0; m_en[i] = 0; m_tog[i] = 0;
      end
      exp_pwm = '0;
      bq.delete();
      rq.delete();
    end else begin
      wacc = awvalid && wvalid && !m_bv;
      racc = arvalid && !m_rv;
      widx = int'(awaddr[AW-1:2]);
      ridx = int'(araddr[AW-1:2]);
      for (int i = 0; i < NC; i++) begin
        exp_pwm[i] = m_gen && m_en[i] &&
                     (m_mode[i] ? m_tog[i] : ((m_ticks % PERIOD) < m_duty[i]));
      end
      if (racc) rq.push_back(m_ok(ridx) ? {2'b00, m_img(ridx)} : {2'b10, 32'h0});
      if (!m_gen) begin
        m_phase = 0; m_ticks = 0;
        for (int i = 0; i < NC; i++) m_tog[i] = 0;
      end else begin
        tick = (m_phase == m_presc);
        wrap = tick && ((m_ticks % PERIOD) == PERIOD - 1);
        if (tick) m_ticks++;
        m_phase = ((wacc && widx == 1) || tick) ? 0 : m_phase + 1;
        for (int i = 0; i < NC; i++) m_tog[i] = !m_en[i] ? 0 : (wrap ? !m_tog[i] : m_tog[i]);
      end
      if (m_bv && bready) m_bv = 0;
      if (wacc) begin
        m_bv = 1;
        bq.push_back(m_ok(widx) ? 2'b00 : 2'b10);
        mrg = m_img(widx);
        for (int b = 0; b < 4; b++) if (wstrb[b]) mrg[8*b +: 8] = wdata[8*b +: 8];
        if (widx == 0) m_gen = mrg[0];
        else if (widx == 1) m_presc = mrg[PSW-1:0];
        else if (widx >= 4 && widx < 4 + NC) begin
          m_duty[widx-4] = mrg[PW-1:0];
          m_mode[widx-4] = mrg[16];
          m_en[widx-4]   = mrg[31];
        end
      end
      if (m_rv && rready) m_rv = 0;
      if (racc) m_rv = 1;
    end
  end

  // Monitor: handshakes and LEDs every cycle, responses popped from the scoreboard.
  always @(negedge clk) begin
    logic [33:0] er;
    logic [1:0]  eb;
    if (!rst) begin
      check("awready", awready, awvalid && wvalid && !m_bv);
      check("wready",  wready,  awvalid && wvalid && !m_bv);
      check("arready", arready, arvalid && !m_rv);
      check("bvalid",  bvalid,  m_bv);
      check("rvalid",  rvalid,  m_rv);
      check("pwm_out", pwm_out, exp_pwm);
      if (bvalid && bready) begin
        if (bq.size() == 0) timeout_fail("bresp_unexpected");
        else begin
          eb = bq.pop_front();
          check("bresp", bresp, eb);
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) timeout_fail("rdata_unexpected");
        else begin
          er = rq.pop_front();
          check("rdata", rdata, er[31:0]);
          check("rresp", rresp, er[33:32]);
        end
      end
    end
  end

  initial begin
    bready = 0;
    rready = 0;
    forever begin
      @(posedge clk); #1;
      if (b_hold > 0) begin
        bready = 0;
        b_hold--;
      end else begin
        bready = ($urandom_range(0, 3) != 0);
      end
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic axil_write(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead);
    bit done;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1;
    repeat (lead) begin @(posedge clk); #1; end
    wvalid = 1;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (awready && wready) done = 1;
    end
    if (!done) timeout_fail("write_accept");
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axil_read(input logic [AW-1:0] a);
    bit done;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (arready) done = 1;
    end
    if (!done) timeout_fail("read_accept");
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  initial begin
    int hi;
    int cyc;
    int stamps [$];
    logic prev;
    bit drained;
    rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; wdata = 0; wstrb = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    @(posedge clk); #1;
    rst = 0;

    axil_read(6'h08);
    axil_read(6'h00);
    repeat (20) @(posedge clk);

    axil_write(6'h00, 32'h1, 4'hF, 0);
    axil_write(6'h04, 32'h0, 4'hF, 0);
    axil_write(6'h10, 32'h8000_0040, 4'hF, 0);
    repeat (300) @(posedge clk);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out[0]) hi++;
    end
    check("ch0_high_per_period", hi, 64);

    axil_write(6'h14, 32'h8001_0000, 4'hF, 0);
    axil_write(6'h04, 32'h3, 4'hF, 0);
    repeat (1500) @(posedge clk);
    axil_write(6'h04, 32'h3, 4'hF, 0);
    @(negedge clk);
    prev = pwm_out[1];
    cyc = 0;
    while (stamps.size() < 2 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pwm_out[1] !== prev) begin
        stamps.push_back(cyc);
        prev = pwm_out[1];
      end
    end
    if (stamps.size() < 2) timeout_fail("blink_toggle");
    else check("blink_half_period", stamps[1] - stamps[0], 1024);

    axil_write(6'h3C, 32'hFFFF_FFFF, 4'hF, 0);
    axil_read(6'h3C);

    b_hold = 9;
    axil_write(6'h20, 32'h8000_0080, 4'hF, 5);
    axil_write(6'h24, 32'h8001_0000, 4'hF, 0);

    axil_write(6'h18, 32'hFFFF_FF80, 4'b0001, 0);
    axil_read(6'h18);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        axil_write(AW'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2));
      else
        axil_read(AW'($urandom_range(0, 63)));
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    for (int a = 0; a < 64; a += 4) axil_read(AW'(a));

    drained = 0;
    for (int c = 0; c < 500 && !drained; c++) begin
      @(negedge clk);
      if (bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid) drained = 1;
    end
    if (!drained) timeout_fail("scoreboard_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_led_pwm.md
Name: axil_led_pwm

Overview:
- AXI4-Lite slave with N_CHANNELS independent LED outputs. Each channel runs in PWM (brightness) or blink mode.
- Sits on an HPM0_FPD master port in place of a plain LED register. The fabric top maps pwm_out bits onto the RGB LED pins.
- All channels share one prescaler and one period counter, so they stay phase-aligned.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- ADDR_WIDTH, 6, AXI-Lite byte-address bits decoded; must satisfy 4*(4+N_CHANNELS) <= 2**ADDR_WIDTH.
- N_CHANNELS, 6, number of LED outputs (1..16).
- PWM_WIDTH, 8, period counter and duty width (1..16).
- PRESCALE_WIDTH, 16, prescaler register width (1..32).

Ports:
- axi_clock  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1
- s_axil_awready  out  1
- s_axil_wdata  in  32
- s_axil_wstrb  in  4  byte enables.
- s_axil_wvalid  in  1
- s_axil_wready  out  1
- s_axil_bresp  out  2
- s_axil_bvalid  out  1
- s_axil_bready  in  1
- s_axil_araddr  in  ADDR_WIDTH
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1
- s_axil_arready  out  1
- s_axil_rdata  out  32
- s_axil_rresp  out  2
- s_axil_rvalid  out  1
- s_axil_rready  in  1
- pwm_out  out  N_CHANNELS  registered LED drive; bit i is channel i.

Behaviour:
- Reset: every ready/valid output is 0, bresp/rresp 2'b00, rdata 0, pwm_out 0, all registers 0, all counters 0, blink toggles 0.
- Register map (byte address; address bits [1:0] ignored):
  - 0x00 CTRL: bit0 GEN (global enable); other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_WIDTH-1:0].
  - 0x08 INFO, read-only: [7:0]=N_CHANNELS, [15:8]=PWM_WIDTH; writes ignored but return OKAY.
  - 0x0C reserved: reads 0, OKAY.
  - 0x10+4*i CHi: [PWM_WIDTH-1:0] duty, bit16 MODE (0=PWM, 1=blink), bit31 EN.
  - Any other address: resp 2'b10 SLVERR; read data 0; write has no effect.
  - Unimplemented bits read 0.
- Write channel:
  - Accept only when awvalid and wvalid are both high and bvalid is 0.
  - awready and wready pulse high together for exactly that cycle.
  - The register updates on the accept edge, per byte according to wstrb.
  - bvalid rises the next cycle and holds until bready; no new write is accepted while bvalid=1.
- Read channel:
  - arready pulses one cycle when arvalid=1 and rvalid=0.
  - rdata and rresp are registered; rvalid rises the next cycle and holds, with data stable, until rready.
- Read and write are independent and may complete in the same cycle. A read accepted in the same cycle as a write to the same register returns the old value.
- Prescaler:
  - While GEN=1, pcnt counts 0..PRESCALE, then wraps to 0.
  - tick=1 in the cycle pcnt==PRESCALE; PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE clears pcnt to 0 on the accept edge.
- Period counter:
  - cnt (PWM_WIDTH bits) increments on tick and wraps from 2**PWM_WIDTH-1 to 0.
  - wrap = tick && cnt==all-ones.
- Channel output, computed then registered (pwm_out lags the counter state by 1 cycle):
  - EN=0 or GEN=0: 0.
  - MODE=0: (cnt < duty). Duty 0 gives constant 0; duty all-ones gives high (2**PWM_WIDTH-1) of 2**PWM_WIDTH counts.
  - MODE=1: the channel toggle flop inverts on wrap; output is the toggle. The toggle is cleared while EN=0.
- GEN=0: pcnt, cnt and all toggles are held at 0. Counting restarts from 0 when GEN is set to 1.
- Reset mid-transaction: all handshake state is dropped, with no response issued. The master must reissue.

Test Plan:
- Reset, then read 0x08 -> rdata 0x0000_0806, rresp 00. Read 0x00 -> 0. pwm_out stays 0.
- Write CTRL=1, PRESCALE=0, CH0=0x8000_0040 (duty 64) -> pwm_out[0] high for exactly 64 of every 256 cycles, steady state, period 256 cycles.
- Write CH1=0x8001_0000 (blink), PRESCALE=3 -> pwm_out[1] toggles every 1024 cycles. Rewriting PRESCALE mid-count restarts the prescaler from 0.
- Write 0x3C with N_CHANNELS=6 -> bresp 10. A read of the same address returns rresp 10, rdata 0. No register changes.
- awvalid asserted 5 cycles before wvalid, with bready held low for 3 cycles -> single accept; bvalid held until bready; a second write stalls (awready=0) until B completes.
- Write CH2 with wstrb=4'b0001, data 0xFFFF_FF80 over old 0 -> CH2 reads 0x0000_0080, EN still 0, pwm_out[2]=0.
